bit_scan_unit: RTL and testbench

Multi-cycle, parametrised bit-position finder for the CPU's execution stage. It locates the lowest or highest set or clear bit of a WIDTH-bit operand, examining CHUNK bits per cycle under a start/busy/done handshake, the same way the multiply/divide unit is driven. The pipeline stalls on `busy` and captures `result`/`found` on `done`.

---
 rtl/bit_scan_unit_if.sv | 36 +++
 rtl/bit_scan_unit.sv | 166 ++++++++++++++++
 tb/tb_bit_scan_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/bit_scan_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : bit_scan_unit_if
// Description : Handshake/operand bundle for bit_scan_unit.
//               master : start, data, type_sel out; busy, done, result, found in
//               slave  : the mirror image (used by bit_scan_unit)
//               type_sel carries the 2-bit scan mode ("type" is a reserved
//               word in SystemVerilog, so it cannot be used as a name):
//                 00 lowest 1, 01 lowest 0, 10 highest 1, 11 highest 0
// Revision    : 1.0 - initial release
// ============================================================================
interface bit_scan_unit_if #(
  parameter int WIDTH = 32,
  parameter int RW    = $clog2(WIDTH + 1)
) ();

  logic             start;
  logic [WIDTH-1:0] data;
  logic [1:0]       type_sel;
  logic             busy;
  logic             done;
  logic [RW-1:0]    result;
  logic             found;

  modport master (
    output start, data, type_sel,
    input  busy, done, result, found
  );

  modport slave (
    input  start, data, type_sel,
    output busy, done, result, found
  );

endinterface
`default_nettype wire

// File: rtl/bit_scan_unit.sv
`default_nettype none
// ============================================================================
// Module      : bit_scan_unit
// Description : Multi-cycle bit-position finder. Locates the lowest/highest
//               set/clear bit of a WIDTH-bit operand, examining CHUNK bits per
//               cycle under a start/busy/done handshake.
// Ports       : clk    - clock, rising edge
//               reset  - synchronous, active-high
//               bus    - bit_scan_unit_if.slave (start, data, type_sel in;
//                        busy, done, result, found out)
// Parameters  : WIDTH  - operand width, multiple of CHUNK
//               CHUNK  - bits examined per scan cycle (power of two)
//               RW     - result width, derived, do not override
// Config      : `BITSCAN_EARLY_EXIT_EN - when defined, the scan stops on the
//               first chunk that contains a match (data-dependent latency);
//               when undefined, all WIDTH/CHUNK chunks are always scanned.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_scan_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4,
  parameter int RW    = $clog2(WIDTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  bit_scan_unit_if.slave bus
);

  localparam int             N        = WIDTH / CHUNK;
  localparam int             KW       = (N > 1) ? $clog2(N) : 1;
  localparam int             PW       = (CHUNK > 1) ? $clog2(CHUNK) : 1;
  localparam logic [KW-1:0]  K_LAST   = KW'(N - 1);
  localparam logic [RW-1:0]  NONE_IDX = RW'(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q,   state_d;
  logic [KW-1:0]    k_q,       k_d;
  logic [WIDTH-1:0] data_q,    data_d;
  logic [1:0]       type_q,    type_d;
  logic             hit_q,     hit_d;
  logic [RW-1:0]    hit_idx_q, hit_idx_d;
  logic [RW-1:0]    result_q,  result_d;
  logic             found_q,   found_d;

  // Chunk datapath (driven only from registers)
  logic [CHUNK-1:0] chunks [N];
  logic [KW-1:0]    chunk_sel;
  logic [CHUNK-1:0] chunk_bits;
  logic             chunk_hit;
  logic [PW-1:0]    chunk_pos;
  logic [RW-1:0]    chunk_idx;
  logic             scan_last;

  for (genvar g = 0; g < N; g++) begin : g_chunks
    assign chunks[g] = data_q[g*CHUNK +: CHUNK];
  end

  always_comb begin
    // High modes walk the chunks from the top of the operand downward.
    chunk_sel  = type_q[1] ? (K_LAST - k_q) : k_q;
    // Clear-bit modes become set-bit searches on the inverted chunk.
    chunk_bits = type_q[0] ? ~chunks[chunk_sel] : chunks[chunk_sel];
    chunk_hit  = 1'b0;
    chunk_pos  = '0;
    // Low modes keep the first (lowest) match; high modes let later,
    // higher matches overwrite so the highest one survives.
    for (int i = 0; i < CHUNK; i++) begin
      if (chunk_bits[i] && (!chunk_hit || type_q[1])) begin
        chunk_pos = PW'(i);
      end
      if (chunk_bits[i]) begin
        chunk_hit = 1'b1;
      end
    end
    chunk_idx = RW'(chunk_sel) * RW'(CHUNK) + RW'(chunk_pos);
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    data_d    = data_q;
    type_d    = type_q;
    hit_d     = hit_q;
    hit_idx_d = hit_idx_q;
    result_d  = result_q;
    found_d   = found_q;
    scan_last = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_SCAN;
          data_d    = bus.data;
          type_d    = bus.type_sel;
          k_d       = '0;
          hit_d     = 1'b0;
          hit_idx_d = '0;
        end
      end

      ST_SCAN: begin
        // Only the first matching chunk is recorded.
        if (chunk_hit && !hit_q) begin
          hit_d     = 1'b1;
          hit_idx_d = chunk_idx;
        end
        k_d = k_q + 1'b1;
`ifdef BITSCAN_EARLY_EXIT_EN
        scan_last = chunk_hit || (k_q == K_LAST);
`else
        scan_last = (k_q == K_LAST);
`endif
        // Visible result/found are only updated on the way into DONE so
        // they hold steady for the whole scan.
        if (scan_last) begin
          state_d  = ST_DONE;
          k_d      = '0;
          found_d  = hit_d;
          result_d = hit_d ? hit_idx_d : NONE_IDX;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      data_q    <= '0;
      type_q    <= '0;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
      result_q  <= '0;
      found_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      data_q    <= data_d;
      type_q    <= type_d;
      hit_q     <= hit_d;
      hit_idx_q <= hit_idx_d;
      result_q  <= result_d;
      found_q   <= found_d;
    end
  end

  assign bus.busy   = (state_q == ST_SCAN);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.result = result_q;
  assign bus.found  = found_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_scan_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_scan_unit
// Description : Self-checking bench for bit_scan_unit (WIDTH=32, CHUNK=4).
//               Directed cases plus randomized operands against a bit-level
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_scan_unit;

  localparam int WIDTH = 32;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;
  localparam int RW    = $clog2(WIDTH + 1);

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bit_scan_unit_if #(.WIDTH(WIDTH)) bus ();

  bit_scan_unit #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Last result/found the design should be presenting.
  int exp_res = 0;
  int exp_fnd = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Reference: scan the operand bit by bit from the chosen end.
  function automatic void model(input logic [31:0] d, input logic [1:0] t,
                                output int res, output int fnd, output int lat);
    logic [31:0] v;
    v   = t[0] ? ~d : d;
    res = WIDTH;
    fnd = 0;
    if (!t[1]) begin
      for (int i = 0; i < WIDTH; i++)
        if (v[i] && fnd == 0) begin res = i; fnd = 1; end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (v[i] && fnd == 0) begin res = i; fnd = 1; end
    end
    lat = N;
`ifdef BITSCAN_EARLY_EXIT_EN
    // Position of the matching chunk in scan order, plus one edge.
    if (fnd != 0) lat = (t[1] ? (N - 1 - res / CHUNK) : (res / CHUNK)) + 1;
`endif
  endfunction

  task automatic expect_quiet(input string tag, input int cycles);
    int cnt;
    cnt = 0;
    for (int j = 0; j < cycles; j++) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
    check(tag, 32'(cnt), 32'd0);
  endtask

  // One complete operation. With poke set, a second start is pulsed while
  // the scan is running and must be ignored.
  task automatic do_op(input logic [31:0] d, input logic [1:0] t, input bit poke);
    int er, ef, el, lat;
    model(d, t, er, ef, el);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.data     = d;
    bus.type_sel = t;
    @(negedge clk);                 // E0 has accepted the operand
    bus.start    = 1'b0;
    bus.data     = $urandom;        // later operand changes must not matter
    bus.type_sel = 2'($urandom_range(0, 3));
    check("busy_scan", 32'(bus.busy), 32'd1);
    check("hold_scan", {31'd0, bus.found} << RW | 32'(bus.result),
          (32'(exp_fnd) << RW) | 32'(exp_res));
    lat = 0;
    for (int j = 1; j <= N + 1; j++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = j;
        break;
      end
      check("busy_scan", 32'(bus.busy), 32'd1);
      if (poke && j == 1) begin
        bus.start    = 1'b1;
        bus.data     = 32'h1;
        bus.type_sel = 2'b00;
      end
      if (poke && j == 2) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    check("latency", 32'(lat), 32'(el));
    check("result", 32'(bus.result), 32'(er));
    check("found", 32'(bus.found), 32'(ef));
    check("busy_done", 32'(bus.busy), 32'd0);
    exp_res = er;
    exp_fnd = ef;
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 32'd0);
    if (poke) expect_quiet("no_queued_start", N + 3);
  endtask

  task automatic wait_done(output int got);
    got = 0;
    for (int j = 0; j < 3 * N; j++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] d;
    int          got;

    // Reset held together with start: reset must win.
    reset        = 1'b1;
    bus.start    = 1'b1;
    bus.data     = 32'h0000_0001;
    bus.type_sel = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_found", 32'(bus.found), 32'd0);
    bus.start = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // Directed cases
    do_op(32'h0000_0100, 2'b00, 1'b0);
    do_op(32'hFFFF_FFFF, 2'b01, 1'b0);
    do_op(32'h0000_0000, 2'b10, 1'b0);
    do_op(32'h0001_0000, 2'b10, 1'b0);
    do_op(32'h7FFF_FFFF, 2'b11, 1'b0);
    do_op(32'h8000_0000, 2'b00, 1'b1);

    // Reset in the middle of a scan
    @(negedge clk);
    bus.start    = 1'b1;
    bus.data     = 32'h8000_0000;
    bus.type_sel = 2'b00;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;                   // sampled at E3
    @(negedge clk);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_result", 32'(bus.result), 32'd0);
    check("midrst_found", 32'(bus.found), 32'd0);
    reset   = 1'b0;
    exp_res = 0;
    exp_fnd = 0;
    expect_quiet("midrst_quiet", N + 3);
    do_op(32'h0000_0004, 2'b00, 1'b0);

    // Back-to-back with start held high
    @(negedge clk);
    bus.start    = 1'b1;
    bus.data     = 32'h1;
    bus.type_sel = 2'b00;
    wait_done(got);
    check("b2b_done0", 32'(got), 32'd1);
    check("b2b_res0", 32'(bus.result), 32'd0);
    bus.data = 32'h2;
    wait_done(got);
    check("b2b_done1", 32'(got), 32'd1);
    check("b2b_res1", 32'(bus.result), 32'd1);
    bus.start = 1'b0;
    exp_res   = 1;
    exp_fnd   = 1;
    expect_quiet("b2b_quiet", N + 3);

    // Randomized operands, biased toward single-bit and extreme patterns
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       d = $urandom;
        1:       d = 32'h1 << $urandom_range(0, 31);
        2:       d = ~(32'h1 << $urandom_range(0, 31));
        default: d = ($urandom_range(0, 1) != 0) ? 32'h0 : 32'hFFFF_FFFF;
      endcase
      do_op(d, 2'($urandom_range(0, 3)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
